shadow_pixel_streamer: RTL and testbench

Producer end of the centroid/edge-detection pixel interface. It consumes the raster camera stream (hcount, vcount, luma), thresholds each pixel inside a region of interest, and emits the coordinates of every "shadow" (dark) pixel as a valid-qualified stream. It pulses tabulate_out once per accumulation window, after the last pixel of that window has been streamed. It sits between the camera/frame-buffer read path and the sundial edge-detection stage.

---
 rtl/shadow_stream_pkg.sv | 15 +
 rtl/shadow_threshold_stage.sv | 69 ++++++
 rtl/shadow_pixel_streamer.sv | 129 ++++++++++++
 tb/tb_shadow_pixel_streamer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/shadow_stream_pkg.sv
// Shared types and geometry defaults for the shadow pixel streamer.
package shadow_stream_pkg;

    localparam int unsigned XW         = 11;
    localparam int unsigned YW         = 10;
    localparam int unsigned HActiveDef = 1280;
    localparam int unsigned VActiveDef = 720;

    typedef enum logic [1:0] {
        StSync,
        StStream,
        StFlush
    } stream_state_e;

endpackage

// File: rtl/shadow_threshold_stage.sv
// First pipeline stage: registers the raster position and flags shadow / last-pixel hits.
module shadow_threshold_stage
    import shadow_stream_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = HActiveDef,
    parameter int unsigned V_ACTIVE  = VActiveDef,
    parameter int unsigned ROI_X_MIN = 0,
    parameter int unsigned ROI_X_MAX = HActiveDef - 1,
    parameter int unsigned ROI_Y_MIN = 0,
    parameter int unsigned ROI_Y_MAX = VActiveDef - 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          pixel_valid_in,
    input  logic [XW-1:0] hcount_in,
    input  logic [YW-1:0] vcount_in,
    input  logic [7:0]    luma_in,
    input  logic [7:0]    threshold_in,
    output logic          hit_out,
    output logic [XW-1:0] x_out,
    output logic [YW-1:0] y_out,
    output logic          last_out
);

    localparam logic [XW-1:0] HLast   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] VLast   = YW'(V_ACTIVE - 1);
    localparam logic [XW-1:0] RoiXMin = XW'(ROI_X_MIN);
    localparam logic [XW-1:0] RoiXMax = XW'(ROI_X_MAX);
    localparam logic [YW-1:0] RoiYMin = YW'(ROI_Y_MIN);
    localparam logic [YW-1:0] RoiYMax = YW'(ROI_Y_MAX);

    logic x_lo_ok, y_lo_ok;
    logic in_active, in_roi, hit_d, last_d;

    // A zero lower bound is always satisfied; skip the degenerate unsigned compare.
    if (ROI_X_MIN == 0) begin : g_x_lo_open
        assign x_lo_ok = 1'b1;
    end else begin : g_x_lo
        assign x_lo_ok = (hcount_in >= RoiXMin);
    end

    if (ROI_Y_MIN == 0) begin : g_y_lo_open
        assign y_lo_ok = 1'b1;
    end else begin : g_y_lo
        assign y_lo_ok = (vcount_in >= RoiYMin);
    end

    always_comb begin
        in_active = (hcount_in <= HLast) && (vcount_in <= VLast);
        in_roi    = x_lo_ok && (hcount_in <= RoiXMax) && y_lo_ok && (vcount_in <= RoiYMax);
        hit_d     = pixel_valid_in && in_active && in_roi && (luma_in < threshold_in);
        last_d    = pixel_valid_in && (hcount_in == HLast) && (vcount_in == VLast);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hit_out  <= 1'b0;
            last_out <= 1'b0;
            x_out    <= '0;
            y_out    <= '0;
        end else begin
            hit_out  <= hit_d;
            last_out <= last_d;
            x_out    <= hcount_in;
            y_out    <= vcount_in;
        end
    end

endmodule

// File: rtl/shadow_pixel_streamer.sv
// Streams coordinates of dark pixels inside an ROI and pulses a per-window shadow count.
module shadow_pixel_streamer
    import shadow_stream_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = HActiveDef,
    parameter int unsigned V_ACTIVE  = VActiveDef,
    parameter int unsigned ROI_X_MIN = 0,
    parameter int unsigned ROI_X_MAX = HActiveDef - 1,
    parameter int unsigned ROI_Y_MIN = 0,
    parameter int unsigned ROI_Y_MAX = VActiveDef - 1,
    parameter int unsigned FRAME_DIV = 1,
    parameter int unsigned COUNT_W   = 20
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [XW-1:0]      hcount_in,
    input  logic [YW-1:0]      vcount_in,
    input  logic [7:0]         luma_in,
    input  logic               pixel_valid_in,
    input  logic [7:0]         threshold_in,
    output logic [XW-1:0]      x_out,
    output logic [YW-1:0]      y_out,
    output logic               valid_out,
    output logic               tabulate_out,
    output logic [COUNT_W-1:0] pixel_count_out,
    output logic               count_valid_out
);

    localparam int unsigned        FrameW    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [FrameW-1:0]  FrameLast = FrameW'(FRAME_DIV - 1);
    localparam logic [COUNT_W-1:0] CountMax  = '1;

    stream_state_e      state_q;
    logic [FrameW-1:0]  frame_cnt_q;
    logic [COUNT_W-1:0] cnt_q;
    logic [7:0]         thr_q;

    logic               frame_start, accept, window_end;
    logic [7:0]         thr_use;
    logic [COUNT_W-1:0] cnt_sat;
    logic               s1_hit, s1_last;
    logic [XW-1:0]      s1_x;
    logic [YW-1:0]      s1_y;

    always_comb begin
        frame_start = pixel_valid_in && (hcount_in == '0) && (vcount_in == '0);
        // In SYNC only the frame-start pixel may enter the pipeline.
        accept      = pixel_valid_in && ((state_q != StSync) || frame_start);
        thr_use     = frame_start ? threshold_in : thr_q;
        window_end  = s1_last && (frame_cnt_q == FrameLast);
        cnt_sat     = cnt_q;
        if (s1_hit && (cnt_q != CountMax)) begin
            cnt_sat = cnt_q + 1'b1;
        end
    end

    shadow_threshold_stage #(
        .H_ACTIVE  (H_ACTIVE),
        .V_ACTIVE  (V_ACTIVE),
        .ROI_X_MIN (ROI_X_MIN),
        .ROI_X_MAX (ROI_X_MAX),
        .ROI_Y_MIN (ROI_Y_MIN),
        .ROI_Y_MAX (ROI_Y_MAX)
    ) u_threshold (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .pixel_valid_in (accept),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .luma_in        (luma_in),
        .threshold_in   (thr_use),
        .hit_out        (s1_hit),
        .x_out          (s1_x),
        .y_out          (s1_y),
        .last_out       (s1_last)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q         <= StSync;
            frame_cnt_q     <= '0;
            cnt_q           <= '0;
            thr_q           <= '0;
            x_out           <= '0;
            y_out           <= '0;
            valid_out       <= 1'b0;
            tabulate_out    <= 1'b0;
            pixel_count_out <= '0;
            count_valid_out <= 1'b0;
        end else begin
            if (frame_start) begin
                thr_q <= threshold_in;
            end
            valid_out <= s1_hit;
            if (s1_hit) begin
                x_out <= s1_x;
                y_out <= s1_y;
            end
            if (s1_last) begin
                frame_cnt_q <= window_end ? '0 : frame_cnt_q + 1'b1;
            end
            tabulate_out    <= 1'b0;
            count_valid_out <= 1'b0;
            case (state_q)
                StSync: begin
                    if (frame_start) begin
                        state_q <= StStream;
                    end
                end
                StStream: begin
                    cnt_q <= cnt_sat;
                    if (window_end) begin
                        state_q <= StFlush;
                    end
                end
                StFlush: begin
                    // Publish the closed window; the pixel now in stage 1 opens the next one.
                    tabulate_out    <= 1'b1;
                    count_valid_out <= 1'b1;
                    pixel_count_out <= cnt_q;
                    cnt_q           <= COUNT_W'(s1_hit);
                    state_q         <= window_end ? StFlush : StStream;
                end
                default: state_q <= StSync;
            endcase
        end
    end

endmodule

// File: tb/tb_shadow_pixel_streamer.sv
// Directed bench: ROI 100..200 in x, two frames per window, 4-bit saturating count.
module tb_shadow_pixel_streamer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [7:0]  luma_in;
    logic        pixel_valid_in;
    logic [7:0]  threshold_in;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic        valid_out;
    logic        tabulate_out;
    logic [3:0]  pixel_count_out;
    logic        count_valid_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    shadow_pixel_streamer #(
        .H_ACTIVE  (1280),
        .V_ACTIVE  (720),
        .ROI_X_MIN (100),
        .ROI_X_MAX (200),
        .ROI_Y_MIN (0),
        .ROI_Y_MAX (719),
        .FRAME_DIV (2),
        .COUNT_W   (4)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .hcount_in       (hcount_in),
        .vcount_in       (vcount_in),
        .luma_in         (luma_in),
        .pixel_valid_in  (pixel_valid_in),
        .threshold_in    (threshold_in),
        .x_out           (x_out),
        .y_out           (y_out),
        .valid_out       (valid_out),
        .tabulate_out    (tabulate_out),
        .pixel_count_out (pixel_count_out),
        .count_valid_out (count_valid_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one valid pixel for one cycle; returns on the following falling edge.
    task automatic drive(input logic [10:0] h, input logic [9:0] v, input logic [7:0] l);
        hcount_in      = h;
        vcount_in      = v;
        luma_in        = l;
        pixel_valid_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic idle();
        pixel_valid_in = 1'b0;
        hcount_in      = 11'd0;
        vcount_in      = 10'd0;
        @(negedge clk_in);
    endtask

    task automatic chk_tab(input string tag, input logic tab, input logic [3:0] cnt);
        chk({tag, "_tab"}, tabulate_out, tab);
        chk({tag, "_cv"}, count_valid_out, tab);
        chk({tag, "_cnt"}, pixel_count_out, cnt);
    endtask

    initial begin
        rst_in         = 1'b1;
        threshold_in   = 8'd128;
        pixel_valid_in = 1'b0;
        hcount_in      = 11'd0;
        vcount_in      = 10'd0;
        luma_in        = 8'd0;
        idle();
        idle();
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_x", x_out, 11'd0);
        chk("rst_y", y_out, 10'd0);
        chk_tab("rst", 1'b0, 4'd0);
        rst_in = 1'b0;

        // SYNC: in-ROI dark pixels before a frame start are ignored.
        drive(11'd150, 10'd50, 8'd0);
        drive(11'd151, 10'd50, 8'd0);
        chk("sync_v0", valid_out, 1'b0);
        drive(11'd152, 10'd50, 8'd0);
        chk("sync_v1", valid_out, 1'b0);
        drive(11'd0, 10'd0, 8'd200);
        chk("sync_v2", valid_out, 1'b0);

        // Two-cycle latency; luma == threshold does not qualify.
        drive(11'd150, 10'd20, 8'd127);
        chk("lat_t1", valid_out, 1'b0);
        drive(11'd150, 10'd21, 8'd128);
        chk("lat_t2_v", valid_out, 1'b1);
        chk("lat_t2_x", x_out, 11'd150);
        chk("lat_t2_y", y_out, 10'd20);
        idle();
        chk("eq_thr_v", valid_out, 1'b0);
        chk("hold_x", x_out, 11'd150);
        chk("hold_y", y_out, 10'd20);
        idle();

        // ROI edges: 99 and 201 rejected, 100 and 200 accepted.
        drive(11'd99, 10'd30, 8'd0);
        drive(11'd100, 10'd30, 8'd0);
        chk("roi99_v", valid_out, 1'b0);
        drive(11'd200, 10'd30, 8'd0);
        chk("roi100_v", valid_out, 1'b1);
        chk("roi100_x", x_out, 11'd100);
        drive(11'd201, 10'd30, 8'd0);
        chk("roi200_v", valid_out, 1'b1);
        chk("roi200_x", x_out, 11'd200);
        idle();
        chk("roi201_v", valid_out, 1'b0);
        chk("roi201_hold", x_out, 11'd200);

        // Mid-frame threshold change is ignored until the next frame start.
        threshold_in = 8'd10;
        drive(11'd150, 10'd40, 8'd50);
        idle();
        chk("midthr_v", valid_out, 1'b1);
        chk("midthr_y", y_out, 10'd40);
        idle();

        // End of frame 1 of 2: no tabulate. Window count so far 4.
        drive(11'd1279, 10'd719, 8'd255);
        idle();
        idle();
        chk_tab("f1_end", 1'b0, 4'd0);

        // Frame 2 uses threshold 10.
        drive(11'd0, 10'd0, 8'd255);
        drive(11'd150, 10'd5, 8'd50);
        drive(11'd150, 10'd6, 8'd9);
        chk("newthr_50", valid_out, 1'b0);
        idle();
        chk("newthr_9_v", valid_out, 1'b1);
        chk("newthr_9_y", y_out, 10'd6);
        for (int i = 0; i < 4; i++) drive(11'(120 + i), 10'd7, 8'd0);
        drive(11'd1279, 10'd719, 8'd255);
        chk("w1_t1_tab", tabulate_out, 1'b0);
        drive(11'd150, 10'd8, 8'd0);
        chk("w1_t2_tab", tabulate_out, 1'b0);
        idle();
        chk_tab("w1_t3", 1'b1, 4'd9);
        chk("w1_t3_newpix_v", valid_out, 1'b1);
        chk("w1_t3_newpix_y", y_out, 10'd8);
        idle();
        chk_tab("w1_t4", 1'b0, 4'd9);

        // Saturation: 1 carried + 20 new dark pixels clamps at 15.
        threshold_in = 8'd128;
        drive(11'd0, 10'd0, 8'd255);
        for (int i = 0; i < 20; i++) drive(11'(100 + i), 10'd9, 8'd0);
        drive(11'd1279, 10'd719, 8'd255);
        idle();
        idle();
        chk("w2_f1_tab", tabulate_out, 1'b0);
        drive(11'd0, 10'd0, 8'd255);
        drive(11'd1279, 10'd719, 8'd255);
        idle();
        idle();
        chk_tab("w2_sat", 1'b1, 4'd15);
        idle();
        chk("w2_pulse", tabulate_out, 1'b0);

        // Reset mid-window discards the partial count; SYNC ignores a stray last pixel.
        drive(11'd0, 10'd0, 8'd255);
        for (int i = 0; i < 3; i++) drive(11'(150 + i), 10'd10, 8'd0);
        rst_in = 1'b1;
        idle();
        idle();
        rst_in = 1'b0;
        chk_tab("rst2", 1'b0, 4'd0);
        drive(11'd1279, 10'd719, 8'd0);
        idle();
        idle();
        chk("sync_last_tab", tabulate_out, 1'b0);
        drive(11'd0, 10'd0, 8'd255);
        drive(11'd150, 10'd11, 8'd0);
        drive(11'd151, 10'd11, 8'd0);
        drive(11'd1279, 10'd719, 8'd255);
        idle();
        idle();
        chk("w3_f1_tab", tabulate_out, 1'b0);
        drive(11'd0, 10'd0, 8'd255);
        drive(11'd1279, 10'd719, 8'd255);
        idle();
        idle();
        chk_tab("w3_after_rst", 1'b1, 4'd2);

        // All-bright window still tabulates with a zero count.
        drive(11'd0, 10'd0, 8'd255);
        drive(11'd150, 10'd12, 8'd200);
        drive(11'd160, 10'd12, 8'd128);
        drive(11'd1279, 10'd719, 8'd255);
        idle();
        idle();
        drive(11'd0, 10'd0, 8'd255);
        drive(11'd1279, 10'd719, 8'd255);
        idle();
        idle();
        chk_tab("w4_bright", 1'b1, 4'd0);
        chk("w4_valid", valid_out, 1'b0);
        idle();
        chk("w4_pulse", count_valid_out, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
